hwpf_nl_issue: RTL and testbench

- Producer side of the next-line prefetcher's request-history FIFO (hwpf_fifo).
- Takes up to INSERTS CPU request addresses per cycle and computes the next-line candidate for each.
- Filters candidates against the FIFO history contents and its own pending entries, then buffers survivors in order.
- Issues buffered candidates to the cache through a valid/ready port. It also drives the FIFO's insert lanes and lock, so accepted candidates are recorded as history.

---
 rtl/hwpf_nl_issue.sv | 149 ++++++++++++++
 tb/tb_hwpf_nl_issue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpf_nl_issue.sv
// Next-line prefetch issue stage: builds line+1 candidates, filters them
// against history and pending entries, buffers and offers them to the cache.
module hwpf_nl_issue #(
  parameter int INSERTS     = 2,
  parameter int QUEUE_DEPTH = 3,
  parameter int PEND_DEPTH  = 4,
  parameter int LINE_BYTES  = 64,
  parameter int PAGE_BYTES  = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  logic [INSERTS-1:0]           cpu_req_valid_i,
  input  logic [INSERTS-1:0][39:0]     cpu_req_addr_i,
  input  logic [QUEUE_DEPTH-1:0][39:0] hist_data_i,
  input  logic [QUEUE_DEPTH-1:0]       hist_valid_i,
  output logic [INSERTS-1:0]           take_req_o,
  output logic [INSERTS-1:0][39:0]     cpu_req_o,
  output logic                         lock_o,
  output logic                         pf_valid_o,
  output logic [39:0]                  pf_addr_o,
  input  logic                         pf_ready_i,
  output logic [15:0]                  drop_cnt_o
);

  localparam int AW = 40;
  localparam int GW = $clog2(PAGE_BYTES);
  localparam int PW = $clog2(PEND_DEPTH);
  localparam int CW = $clog2(PEND_DEPTH + INSERTS + 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_mem [PEND_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_drop;

  logic [AW-1:0]   w_aln  [INSERTS];
  logic [AW-1:0]   w_cand [INSERTS];
  logic [PW-1:0]   w_slot [INSERTS];
  logic [INSERTS-1:0] w_inpage;
  logic [INSERTS-1:0] w_push;
  logic [PEND_DEPTH-1:0] w_pvld;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_npush;
  logic [CW-1:0]   w_ndrop;
  logic [CW-1:0]   w_cnt_n;
  logic [16:0]     w_dsum;
  logic            w_pop;

  assign w_pop   = (r_state == S_OFFER) & pf_ready_i;
  assign w_free  = CW'(PEND_DEPTH) - r_count + CW'(w_pop);
  assign w_cnt_n = r_count + w_npush - CW'(w_pop);
  assign w_dsum  = {1'b0, r_drop} + 17'(w_ndrop);

  // Line-aligned source, next-line candidate and same-page test per lane
  always_comb begin
    for (int i = 0; i < INSERTS; i++) begin
      w_aln[i]    = cpu_req_addr_i[i] & ~AW'(LINE_BYTES - 1);
      w_cand[i]   = w_aln[i] + AW'(LINE_BYTES);
      w_inpage[i] = w_aln[i][AW-1:GW] == w_cand[i][AW-1:GW];
    end
  end

  // Mark buffer slots currently holding a pending entry
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int s = 0; s < PEND_DEPTH; s++) begin
      off       = PW'(s) - r_head;
      w_pvld[s] = {{(CW-PW){1'b0}}, off} < r_count;
    end
  end

  // Filter lanes in priority order and allot free slots
  always_comb begin
    logic               ok;
    logic [CW-1:0]      used;
    logic [INSERTS-1:0] elig;
    w_push  = '0;
    w_ndrop = '0;
    used    = '0;
    elig    = '0;
    ok      = 1'b0;
    for (int i = 0; i < INSERTS; i++) begin
      w_slot[i] = '0;
      ok = rst_ni & enable_i & ~flush_i &
           cpu_req_valid_i[i] & w_inpage[i];
      for (int j = 0; j < QUEUE_DEPTH; j++)
        if (hist_valid_i[j] && hist_data_i[j] == w_cand[i]) ok = 1'b0;
      for (int s = 0; s < PEND_DEPTH; s++)
        if (w_pvld[s] && r_mem[s] == w_cand[i]) ok = 1'b0;
      for (int k = 0; k < i; k++)
        if (elig[k] && w_cand[k] == w_cand[i]) ok = 1'b0;
      elig[i] = ok;
      if (ok) begin
        if (used < w_free) begin
          w_push[i] = 1'b1;
          w_slot[i] = r_tail + used[PW-1:0];
          used      = used + CW'(1);
        end else begin
          w_ndrop = w_ndrop + CW'(1);
        end
      end
    end
    w_npush = used;
  end

  // Drive FIFO insert lanes for candidates that enter the buffer
  always_comb begin
    for (int i = 0; i < INSERTS; i++)
      cpu_req_o[i] = w_push[i] ? w_cand[i] : '0;
  end

  assign take_req_o = w_push;
  assign lock_o     = ~enable_i | flush_i | ~rst_ni;
  assign pf_valid_o = r_state == S_OFFER;
  assign pf_addr_o  = (r_state == S_OFFER) ? r_mem[r_head] : '0;
  assign drop_cnt_o = r_drop;

  // Buffer, pointers, drop counter and issue FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      for (int s = 0; s < PEND_DEPTH; s++) r_mem[s] <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < INSERTS; i++)
        if (w_push[i]) r_mem[w_slot[i]] <= w_cand[i];
      if (w_pop) r_head <= r_head + PW'(1);
      r_tail  <= r_tail + w_npush[PW-1:0];
      r_count <= w_cnt_n;
      r_drop  <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
      r_state <= (w_cnt_n != '0) ? S_OFFER : S_IDLE;
    end
  end

endmodule

// File: tb/tb_hwpf_nl_issue.sv
// Bench for hwpf_nl_issue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_hwpf_nl_issue;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             enable_i;
  logic             flush_i;
  logic [1:0]       cpu_req_valid_i;
  logic [1:0][39:0] cpu_req_addr_i;
  logic [2:0][39:0] hist_data_i;
  logic [2:0]       hist_valid_i;
  logic [1:0]       take_req_o;
  logic [1:0][39:0] cpu_req_o;
  logic             lock_o;
  logic             pf_valid_o;
  logic [39:0]      pf_addr_o;
  logic             pf_ready_i;
  logic [15:0]      drop_cnt_o;

  int n_pass = 0;
  int n_chk  = 0;

  hwpf_nl_issue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .flush_i(flush_i), .cpu_req_valid_i(cpu_req_valid_i),
    .cpu_req_addr_i(cpu_req_addr_i), .hist_data_i(hist_data_i),
    .hist_valid_i(hist_valid_i), .take_req_o(take_req_o),
    .cpu_req_o(cpu_req_o), .lock_o(lock_o), .pf_valid_o(pf_valid_o),
    .pf_addr_o(pf_addr_o), .pf_ready_i(pf_ready_i),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    enable_i        = 1'b1;
    flush_i         = 1'b0;
    cpu_req_valid_i = '0;
    cpu_req_addr_i  = '0;
    hist_valid_i    = '0;
    hist_data_i     = '0;
  endtask

  task automatic test_reset();
    idle_in();
    rst_ni = 1'b0;
    pf_ready_i = 1'b1;
    cpu_req_valid_i = 2'b01;
    cpu_req_addr_i[0] = 40'h1000;
    #3;
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", pf_valid_o); else n_pass++;
    n_chk++; if (pf_addr_o !== 40'h0) $display("FAIL rst_addr: got %h want 0", pf_addr_o); else n_pass++;
    n_chk++; if (take_req_o !== 2'b00) $display("FAIL rst_take: got %b want 00", take_req_o); else n_pass++;
    n_chk++; if (lock_o !== 1'b1) $display("FAIL rst_lock: got %b want 1", lock_o); else n_pass++;
    n_chk++; if (drop_cnt_o !== 16'h0) $display("FAIL rst_drop: got %h want 0", drop_cnt_o); else n_pass++;
    cpu_req_valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pf_ready_i = 1'b1;
    cpu_req_valid_i = 2'b01;
    cpu_req_addr_i[0] = 40'hCAFE0000;
    @(negedge clk_i);
    n_chk++; if (take_req_o !== 2'b01) $display("FAIL basic_take: got %b want 01", take_req_o); else n_pass++;
    n_chk++; if (cpu_req_o[0] !== 40'hCAFE0040) $display("FAIL basic_cpureq: got %h want cafe0040", cpu_req_o[0]); else n_pass++;
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL basic_nolat: got %b want 0", pf_valid_o); else n_pass++;
    tick();
    cpu_req_valid_i = '0;
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== 40'hCAFE0040)
      $display("FAIL basic_issue: got %b/%h want 1/cafe0040", pf_valid_o, pf_addr_o); else n_pass++;
    tick();
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL basic_idle: got %b want 0", pf_valid_o); else n_pass++;
    tick();
  endtask

  task automatic test_hist();
    hist_valid_i = 3'b010;
    hist_data_i[1] = 40'hCAFE0040;
    cpu_req_valid_i = 2'b01;
    cpu_req_addr_i[0] = 40'hCAFE0000;
    @(negedge clk_i);
    n_chk++; if (take_req_o !== 2'b00) $display("FAIL hist_take: got %b want 00", take_req_o); else n_pass++;
    tick();
    cpu_req_addr_i[0] = 40'hCAFE0FC0;
    @(negedge clk_i);
    n_chk++; if (take_req_o !== 2'b00) $display("FAIL page_take: got %b want 00", take_req_o); else n_pass++;
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL hist_valid: got %b want 0", pf_valid_o); else n_pass++;
    tick();
    idle_in();
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b0 || drop_cnt_o !== 16'h0)
      $display("FAIL page_drop: got %b/%h want 0/0", pf_valid_o, drop_cnt_o); else n_pass++;
    tick();
  endtask

  task automatic test_dedup();
    pf_ready_i = 1'b0;
    cpu_req_valid_i = 2'b11;
    cpu_req_addr_i[0] = 40'hCAFE0000;
    cpu_req_addr_i[1] = 40'hCAFE0010;
    @(negedge clk_i);
    n_chk++; if (take_req_o !== 2'b01 || cpu_req_o[1] !== 40'h0)
      $display("FAIL dedup_take: got %b/%h want 01/0", take_req_o, cpu_req_o[1]); else n_pass++;
    tick();
    cpu_req_valid_i = '0;
    pf_ready_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (pf_addr_o !== 40'hCAFE0040) $display("FAIL dedup_one: got %h want cafe0040", pf_addr_o); else n_pass++;
    tick();
    cpu_req_valid_i = 2'b11;
    cpu_req_addr_i[1] = 40'hCAFE0100;
    @(negedge clk_i);
    n_chk++; if (take_req_o !== 2'b11 || cpu_req_o[1] !== 40'hCAFE0140)
      $display("FAIL dual_take: got %b/%h want 11/cafe0140", take_req_o, cpu_req_o[1]); else n_pass++;
    tick();
    cpu_req_valid_i = '0;
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== 40'hCAFE0040)
      $display("FAIL dual_ord0: got %b/%h want 1/cafe0040", pf_valid_o, pf_addr_o); else n_pass++;
    tick();
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== 40'hCAFE0140)
      $display("FAIL dual_ord1: got %b/%h want 1/cafe0140", pf_valid_o, pf_addr_o); else n_pass++;
    tick();
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL dual_idle: got %b want 0", pf_valid_o); else n_pass++;
    tick();
  endtask

  task automatic test_full();
    logic [39:0] a;
    pf_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cpu_req_valid_i = 2'b01;
      cpu_req_addr_i[0] = 40'(k * 4096);
      @(negedge clk_i);
      n_chk++; if (take_req_o[0] !== (k <= 4))
        $display("FAIL full_take%0d: got %b want %b", k, take_req_o[0], k <= 4); else n_pass++;
      tick();
    end
    cpu_req_valid_i = '0;
    @(negedge clk_i);
    n_chk++; if (drop_cnt_o !== 16'd1) $display("FAIL full_drop: got %0d want 1", drop_cnt_o); else n_pass++;
    n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== 40'h1040)
      $display("FAIL full_hold: got %b/%h want 1/1040", pf_valid_o, pf_addr_o); else n_pass++;
    tick();
    pf_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      a = 40'(k * 4096 + 64);
      @(negedge clk_i);
      n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== a)
        $display("FAIL full_drain%0d: got %b/%h want 1/%h", k, pf_valid_o, pf_addr_o, a); else n_pass++;
      tick();
    end
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL full_empty: got %b want 0", pf_valid_o); else n_pass++;
    tick();
  endtask

  task automatic test_full_pop();
    logic [39:0] exp_q [$];
    pf_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cpu_req_valid_i = 2'b01;
      cpu_req_addr_i[0] = 40'(k * 4096);
      tick();
    end
    pf_ready_i = 1'b1;
    cpu_req_addr_i[0] = 40'h6000;
    @(negedge clk_i);
    n_chk++; if (take_req_o !== 2'b01 || cpu_req_o[0] !== 40'h6040)
      $display("FAIL fpop_take: got %b/%h want 01/6040", take_req_o, cpu_req_o[0]); else n_pass++;
    n_chk++; if (pf_addr_o !== 40'h1040) $display("FAIL fpop_head: got %h want 1040", pf_addr_o); else n_pass++;
    tick();
    cpu_req_valid_i = '0;
    exp_q = '{40'h2040, 40'h3040, 40'h4040, 40'h6040};
    foreach (exp_q[k]) begin
      @(negedge clk_i);
      n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== exp_q[k])
        $display("FAIL fpop_drain%0d: got %b/%h want 1/%h", k, pf_valid_o, pf_addr_o, exp_q[k]); else n_pass++;
      tick();
    end
    @(negedge clk_i);
    n_chk++; if (pf_valid_o !== 1'b0 || drop_cnt_o !== 16'd1)
      $display("FAIL fpop_end: got %b/%0d want 0/1", pf_valid_o, drop_cnt_o); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    pf_ready_i = 1'b0;
    for (int k = 7; k <= 9; k++) begin
      cpu_req_valid_i = 2'b01;
      cpu_req_addr_i[0] = 40'(k * 4096);
      tick();
    end
    flush_i = 1'b1;
    cpu_req_addr_i[0] = 40'hC000;
    @(negedge clk_i);
    n_chk++; if (lock_o !== 1'b1) $display("FAIL flush_lock: got %b want 1", lock_o); else n_pass++;
    n_chk++; if (take_req_o !== 2'b00) $display("FAIL flush_take: got %b want 00", take_req_o); else n_pass++;
    n_chk++; if (pf_valid_o !== 1'b1) $display("FAIL flush_pre: got %b want 1", pf_valid_o); else n_pass++;
    tick();
    idle_in();
    pf_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_chk++; if (pf_valid_o !== 1'b0 || lock_o !== 1'b0)
        $display("FAIL flush_post%0d: got %b/%b want 0/0", k, pf_valid_o, lock_o); else n_pass++;
      tick();
    end
    n_chk++; if (drop_cnt_o !== 16'd1) $display("FAIL flush_drop: got %0d want 1", drop_cnt_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    pf_ready_i = 1'b0;
    cpu_req_valid_i = 2'b01;
    cpu_req_addr_i[0] = 40'hA000;
    tick();
    cpu_req_valid_i = '0;
    #2;
    n_chk++; if (pf_valid_o !== 1'b1 || pf_addr_o !== 40'hA040)
      $display("FAIL rmid_pre: got %b/%h want 1/a040", pf_valid_o, pf_addr_o); else n_pass++;
    rst_ni = 1'b0;
    cpu_req_valid_i = 2'b01;
    cpu_req_addr_i[0] = 40'hB000;
    #1;
    n_chk++; if (pf_valid_o !== 1'b0 || pf_addr_o !== 40'h0)
      $display("FAIL rmid_pf: got %b/%h want 0/0", pf_valid_o, pf_addr_o); else n_pass++;
    n_chk++; if (take_req_o !== 2'b00 || lock_o !== 1'b1)
      $display("FAIL rmid_fifo: got %b/%b want 00/1", take_req_o, lock_o); else n_pass++;
    n_chk++; if (drop_cnt_o !== 16'h0) $display("FAIL rmid_drop: got %0d want 0", drop_cnt_o); else n_pass++;
    cpu_req_valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    n_chk++; if (pf_valid_o !== 1'b0) $display("FAIL rmid_post: got %b want 0", pf_valid_o); else n_pass++;
  endtask

  function automatic logic [39:0] rnd_addr();
    logic [39:0] a;
    if ($urandom_range(0, 19) == 0) return 40'hFF_FFFF_FFC0;
    a = 40'h12340000 + 40'($urandom_range(0, 1) * 4096)
      + 40'($urandom_range(0, 63) * 64) + 40'($urandom_range(0, 63));
    if ($urandom_range(0, 7) == 0) a[11:6] = 6'h3F;
    return a;
  endfunction

  task automatic test_random();
    logic [39:0] pend [$];
    logic [39:0] seen [$];
    logic [39:0] ecpu [2];
    logic [39:0] aln, cand, ea;
    logic [1:0]  etake;
    int unsigned mdrop;
    int          free, npush, ndrop;
    bit          ev, pop, ok;
    mdrop = 0;
    pend.delete();
    for (int c = 0; c < 3000; c++) begin
      enable_i   = $urandom_range(0, 9) != 0;
      flush_i    = $urandom_range(0, 29) == 0;
      pf_ready_i = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 2; i++) begin
        cpu_req_valid_i[i] = $urandom_range(0, 9) < 7;
        cpu_req_addr_i[i]  = rnd_addr();
      end
      for (int j = 0; j < 3; j++) begin
        hist_valid_i[j] = $urandom_range(0, 1) == 1;
        hist_data_i[j]  = (rnd_addr() & ~40'h3F) + 40'd64;
      end
      ev = pend.size() != 0;
      ea = ev ? pend[0] : 40'h0;
      pop = ev && pf_ready_i;
      free = 4 - pend.size() + (pop ? 1 : 0);
      npush = 0; ndrop = 0; etake = '0;
      seen.delete();
      for (int i = 0; i < 2; i++) begin
        ecpu[i] = 40'h0;
        aln  = cpu_req_addr_i[i] & ~40'h3F;
        cand = aln + 40'd64;
        ok = cpu_req_valid_i[i] && enable_i && !flush_i &&
             (cand >> 12) == (aln >> 12);
        for (int j = 0; j < 3; j++)
          if (hist_valid_i[j] && hist_data_i[j] == cand) ok = 0;
        foreach (pend[p]) if (pend[p] == cand) ok = 0;
        foreach (seen[p]) if (seen[p] == cand) ok = 0;
        if (ok) begin
          seen.push_back(cand);
          if (npush < free) begin
            etake[i] = 1'b1; ecpu[i] = cand; npush++;
          end else ndrop++;
        end
      end
      @(negedge clk_i);
      n_chk++; if (pf_valid_o !== ev || pf_addr_o !== ea)
        $display("FAIL rnd_pf c%0d: got %b/%h want %b/%h", c, pf_valid_o, pf_addr_o, ev, ea); else n_pass++;
      n_chk++; if (take_req_o !== etake || cpu_req_o[0] !== ecpu[0] || cpu_req_o[1] !== ecpu[1])
        $display("FAIL rnd_take c%0d: got %b/%h/%h want %b/%h/%h", c, take_req_o,
                 cpu_req_o[0], cpu_req_o[1], etake, ecpu[0], ecpu[1]); else n_pass++;
      n_chk++; if (drop_cnt_o !== 16'(mdrop) || lock_o !== (!enable_i || flush_i))
        $display("FAIL rnd_cnt c%0d: got %0d/%b want %0d/%b", c, drop_cnt_o, lock_o,
                 mdrop, !enable_i || flush_i); else n_pass++;
      @(posedge clk_i);
      if (flush_i) pend.delete();
      else begin
        if (pop) void'(pend.pop_front());
        for (int i = 0; i < 2; i++) if (etake[i]) pend.push_back(ecpu[i]);
        mdrop = (mdrop + ndrop > 65535) ? 65535 : mdrop + ndrop;
      end
      #1;
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hist();
    test_dedup();
    test_full();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
